// File: rtl/matmul_core_top.sv
// Square matrix multiplier Z = X * Y with operand/result RAMs, one MAC per cycle.
// Optional build macro MATMUL_SAT_EN: signed operands with saturating Z write-back.
module matmul_core_top #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 6,
    parameter int VECTOR_SIZE = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    output logic                  done,
    input  logic [ADDR_WIDTH-1:0] x_wr_addr,
    input  logic                  x_wr_en,
    input  logic [DATA_WIDTH-1:0] x_din,
    input  logic [ADDR_WIDTH-1:0] y_wr_addr,
    input  logic                  y_wr_en,
    input  logic [DATA_WIDTH-1:0] y_din,
    input  logic [ADDR_WIDTH-1:0] z_rd_addr,
    output logic [DATA_WIDTH-1:0] z_dout
);

    localparam int IDX_W  = $clog2(VECTOR_SIZE + 1);
    localparam int PROD_W = 2 * DATA_WIDTH;
    localparam int ACC_W  = PROD_W + $clog2(VECTOR_SIZE);
    localparam int DEPTH  = 2 ** ADDR_WIDTH;
    localparam logic [IDX_W-1:0] K_END    = IDX_W'(VECTOR_SIZE);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(VECTOR_SIZE - 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t r_state, w_next;
    logic   w_clear, w_busy, w_host_ok, w_k_end, w_last_elem;

    logic [IDX_W-1:0] r_i, r_j, r_k;
    logic             r_vld_p0;
    logic [DATA_WIDTH-1:0] r_x_p0, r_y_p0;
    logic [DATA_WIDTH-1:0] w_z_data;
    logic [ADDR_WIDTH-1:0] w_x_addr, w_y_addr, w_z_addr;

    logic [DATA_WIDTH-1:0] r_x_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_y_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_z_mem [DEPTH];

`ifdef MATMUL_SAT_EN
    logic signed [PROD_W-1:0] w_prod;
    logic signed [ACC_W-1:0]  r_acc, w_sum;

    assign w_prod = PROD_W'($signed(r_x_p0)) * PROD_W'($signed(r_y_p0));

    // Clamp when the bits above the result sign are not a pure sign extension.
    function automatic logic [DATA_WIDTH-1:0] fit_z(input logic [ACC_W-1:0] a);
        if ((&a[ACC_W-1:DATA_WIDTH-1]) || !(|a[ACC_W-1:DATA_WIDTH-1]))
            return a[DATA_WIDTH-1:0];
        else if (a[ACC_W-1])
            return {1'b1, {(DATA_WIDTH-1){1'b0}}};
        else
            return {1'b0, {(DATA_WIDTH-1){1'b1}}};
    endfunction

    assign w_z_data = fit_z(w_sum);
`else
    logic [PROD_W-1:0] w_prod;
    logic [ACC_W-1:0]  r_acc, w_sum;

    assign w_prod = PROD_W'(r_x_p0) * PROD_W'(r_y_p0);

    function automatic logic [DATA_WIDTH-1:0] fit_z(input logic [DATA_WIDTH-1:0] a);
        return a;
    endfunction

    assign w_z_data = fit_z(w_sum[DATA_WIDTH-1:0]);
`endif

    assign w_sum       = r_acc + ACC_W'(w_prod);
    assign w_k_end     = (r_k == K_END);
    assign w_last_elem = (r_i == IDX_LAST) && (r_j == IDX_LAST);
    assign w_x_addr    = ADDR_WIDTH'(r_i * VECTOR_SIZE + r_k);
    assign w_y_addr    = ADDR_WIDTH'(r_k * VECTOR_SIZE + r_j);
    assign w_z_addr    = ADDR_WIDTH'(r_i * VECTOR_SIZE + r_j);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_clear   = 1'b0;
        w_busy    = 1'b0;
        w_host_ok = 1'b1;
        done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next  = S_BUSY;
                    w_clear = 1'b1;
                end
            end
            S_BUSY: begin
                w_busy    = 1'b1;
                w_host_ok = 1'b0;
                if (w_k_end && w_last_elem) w_next = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    w_next  = S_BUSY;
                    w_clear = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Index counters and accumulator; k == N is the write-back slot of each element.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_i      <= '0;
            r_j      <= '0;
            r_k      <= '0;
            r_vld_p0 <= 1'b0;
            r_acc    <= '0;
        end else begin
            r_vld_p0 <= w_busy && !w_k_end;
            if (w_clear) begin
                r_i   <= '0;
                r_j   <= '0;
                r_k   <= '0;
                r_acc <= '0;
            end else if (w_busy) begin
                if (w_k_end) begin
                    r_k   <= '0;
                    r_acc <= '0;
                    if (r_j == IDX_LAST) begin
                        r_j <= '0;
                        r_i <= r_i + 1'b1;
                    end else begin
                        r_j <= r_j + 1'b1;
                    end
                end else begin
                    r_k <= r_k + 1'b1;
                    if (r_vld_p0) r_acc <= w_sum;
                end
            end
        end
    end

    // Stage p0: operand RAM reads (host writes only outside BUSY)
    always_ff @(posedge clock) begin
        if (x_wr_en && w_host_ok) r_x_mem[x_wr_addr] <= x_din;
        r_x_p0 <= r_x_mem[w_x_addr];
    end

    always_ff @(posedge clock) begin
        if (y_wr_en && w_host_ok) r_y_mem[y_wr_addr] <= y_din;
        r_y_p0 <= r_y_mem[w_y_addr];
    end

    // Stage p1: multiply-accumulate result written back to Z
    always_ff @(posedge clock) begin
        if (w_busy && w_k_end) r_z_mem[w_z_addr] <= w_z_data;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) z_dout <= '0;
        else        z_dout <= r_z_mem[z_rd_addr];
    end

endmodule

// File: tb/tb_matmul_core_top.sv
// Bench for matmul_core_top: reference matrix product, scoreboarded Z readback.
module tb_matmul_core_top;

    localparam int DW = 32;
    localparam int AW = 6;
    localparam int N  = 8;
    localparam int NN = N * N;
    localparam int LAT_MIN = NN * (N + 1) - 2;
    localparam int LAT_MAX = NN * (N + 2) + 4;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          done;
    logic [AW-1:0] x_wr_addr = '0;
    logic          x_wr_en   = 1'b0;
    logic [DW-1:0] x_din     = '0;
    logic [AW-1:0] y_wr_addr = '0;
    logic          y_wr_en   = 1'b0;
    logic [DW-1:0] y_din     = '0;
    logic [AW-1:0] z_rd_addr = '0;
    logic [DW-1:0] z_dout;

    always #5 clock = ~clock;

    matmul_core_top #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .VECTOR_SIZE(N)) dut (
        .clock(clock), .reset(reset), .start(start), .done(done),
        .x_wr_addr(x_wr_addr), .x_wr_en(x_wr_en), .x_din(x_din),
        .y_wr_addr(y_wr_addr), .y_wr_en(y_wr_en), .y_din(y_din),
        .z_rd_addr(z_rd_addr), .z_dout(z_dout)
    );

    int n_tests = 0;
    int n_fail  = 0;

    bit [DW-1:0] x_m [NN];
    bit [DW-1:0] y_m [NN];

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] val;
    } exp_t;
    exp_t exp_q [$];

    logic rd_en   = 1'b0;
    logic rd_en_d = 1'b0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: plain row-by-column dot product of the host's view of X and Y.
    function automatic logic [DW-1:0] ref_z(input int r, input int c);
`ifdef MATMUL_SAT_EN
        logic signed [127:0] s, a, b;
        s = '0;
        for (int k = 0; k < N; k++) begin
            a = $signed(x_m[r*N+k]);
            b = $signed(y_m[k*N+c]);
            s = s + a * b;
        end
        if (s > 128'sd2147483647)  return 32'h7FFF_FFFF;
        if (s < -128'sd2147483648) return 32'h8000_0000;
        return s[DW-1:0];
`else
        bit [63:0] s;
        s = '0;
        for (int k = 0; k < N; k++)
            s = s + 64'(x_m[r*N+k]) * 64'(y_m[k*N+c]);
        return s[DW-1:0];
`endif
    endfunction

    // Monitor: a read issued at one falling edge is due at the next one.
    always @(posedge clock) rd_en_d <= rd_en;

    always @(negedge clock) begin : monitor
        exp_t e;
        if (rd_en_d) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL z_read: output with empty scoreboard, got 0x%08h", z_dout);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("z[%0d]", e.addr), z_dout, e.val);
            end
        end
    end

    task automatic load();
        for (int a = 0; a < NN; a++) begin
            x_wr_en = 1'b1;  x_wr_addr = AW'(a);  x_din = x_m[a];
            y_wr_en = 1'b1;  y_wr_addr = AW'(a);  y_din = y_m[a];
            @(negedge clock);
        end
        x_wr_en = 1'b0;
        y_wr_en = 1'b0;
    endtask

    // poke: re-pulse start and hammer X writes while the core is busy.
    task automatic run(input bit poke);
        int cyc;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        cyc = 1;
        check("done_low_in_busy", 32'(done), 32'd0);
        while (!done && cyc < 700) begin
            if (poke) begin
                start     = (cyc == 20);
                x_wr_en   = (cyc >= 30 && cyc < 46 && cyc[0]);
                x_wr_addr = AW'(cyc);
                x_din     = '1;
            end
            @(negedge clock);
            cyc++;
        end
        start   = 1'b0;
        x_wr_en = 1'b0;
        n_tests++;
        if (!done || cyc < LAT_MIN || cyc > LAT_MAX) begin
            n_fail++;
            $display("FAIL done_latency: got done=%0b after %0d cycles, expected done=1 within %0d..%0d",
                     done, cyc, LAT_MIN, LAT_MAX);
        end
    endtask

    task automatic read_all();
        exp_t e;
        for (int a = 0; a < NN; a++) begin
            z_rd_addr = AW'(a);
            rd_en     = 1'b1;
            e.addr    = AW'(a);
            e.val     = ref_z(a / N, a % N);
            exp_q.push_back(e);
            @(negedge clock);
        end
        rd_en = 1'b0;
        repeat (2) @(negedge clock);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clock);
        check("reset_done", 32'(done), 32'd0);
        check("reset_z_dout", z_dout, 32'd0);
        reset = 1'b1;
        @(negedge clock);

        // Identity times ramp reproduces the ramp.
        for (int a = 0; a < NN; a++) begin
            x_m[a] = ((a / N) == (a % N)) ? 32'd1 : 32'd0;
            y_m[a] = DW'(a);
        end
        load();
        run(1'b0);
        read_all();
        repeat (5) @(negedge clock);
        check("done_held", 32'(done), 32'd1);

        for (int a = 0; a < NN; a++) begin
            x_m[a] = 32'd2;
            y_m[a] = 32'd2;
        end
        load();
        run(1'b0);
        read_all();

        // Products of 2**32 overflow the result word.
        for (int a = 0; a < NN; a++) begin
            x_m[a] = 32'h0001_0000;
            y_m[a] = 32'h0001_0000;
        end
        load();
        run(1'b0);
        read_all();

        for (int t = 0; t < 3; t++) begin
            for (int a = 0; a < NN; a++) begin
                case (t)
                    0:       begin x_m[a] = $urandom;                 y_m[a] = $urandom; end
                    1:       begin x_m[a] = $urandom_range(0, 255);   y_m[a] = $urandom_range(0, 255); end
                    default: begin x_m[a] = $urandom_range(0, 65535) - 32'd32768;
                                   y_m[a] = $urandom_range(0, 65535) - 32'd32768; end
                endcase
            end
            load();
            run(1'b0);
            read_all();
            run(1'b0);
            read_all();
        end

        // Start and X writes during BUSY must be ignored.
        run(1'b1);
        read_all();

        for (int a = 0; a < NN; a++) begin
            x_m[a] = $urandom;
            y_m[a] = $urandom_range(0, 1023);
        end
        load();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (99) @(negedge clock);
        reset = 1'b0;
        #1;
        check("abort_done", 32'(done), 32'd0);
        check("abort_z_dout", z_dout, 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("abort_idle_done", 32'(done), 32'd0);
        run(1'b0);
        read_all();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
